// File: rtl/tempsens_vdac_ctrl.sv
// rtl/tempsens_vdac_ctrl.sv - VDAC sequencing controller: static, ramp-up, ramp-down and SAR conversions
// Optional feature macro: TEMPSENS_VDAC_CTRL_SYNC_EN (2-flop comparator synchroniser, SETTLE lengthened by 2).
module tempsens_vdac_ctrl #(
  parameter int BITWIDTH      = 6,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [1:0]          i_mode,
  input  logic [BITWIDTH-1:0] i_code,
  input  logic                i_comp,
  output logic [BITWIDTH-1:0] o_dac_data,
  output logic                o_dac_enable,
  output logic                o_busy,
  output logic                o_done,
  output logic [BITWIDTH-1:0] o_result,
  output logic                o_trip
);

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_UP     = 2'd1;
  localparam logic [1:0] MODE_DOWN   = 2'd2;
  localparam logic [1:0] MODE_SAR    = 2'd3;

`ifdef TEMPSENS_VDAC_CTRL_SYNC_EN
  // Two extra settle cycles let the synchronised comparator catch up with the current code.
  localparam int SETTLE_LEN = SETTLE_CYCLES + 2;
`else
  localparam int SETTLE_LEN = SETTLE_CYCLES;
`endif

  localparam int CW = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;
  localparam int IW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  localparam logic [CW-1:0]       CNT_LOAD = CW'(SETTLE_LEN - 1);
  localparam logic [IW-1:0]       MSB_IDX  = IW'(BITWIDTH - 1);
  localparam logic [BITWIDTH-1:0] CODE_MAX = {BITWIDTH{1'b1}};
  localparam logic [BITWIDTH-1:0] CODE_MSB = {1'b1, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [BITWIDTH-1:0] code_q, code_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       bit_q, bit_d;
  logic [BITWIDTH-1:0] result_q, result_d;
  logic                trip_q, trip_d;

  logic                comp_s;
  logic [BITWIDTH-1:0] first_code;
  logic [BITWIDTH-1:0] sar_next;

`ifdef TEMPSENS_VDAC_CTRL_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_comp};
    end
  end

  assign comp_s = sync_q[1];
`else
  assign comp_s = i_comp;
`endif

  // Initial DAC code for the requested mode, taken straight from the start-time inputs.
  always_comb begin
    first_code = '0;
    case (i_mode)
      MODE_STATIC: first_code = i_code;
      MODE_UP:     first_code = '0;
      MODE_DOWN:   first_code = CODE_MAX;
      MODE_SAR:    first_code = CODE_MSB;
      default:     first_code = '0;
    endcase
  end

  // SAR trial update: drop the bit under test when the DAC is too high, then try the next bit down.
  always_comb begin
    sar_next = code_q;
    if (comp_s) begin
      sar_next[bit_q] = 1'b0;
    end
    if (bit_q != '0) begin
      sar_next[bit_q - 1'b1] = 1'b1;
    end
  end

  // Next-state and datapath update for the conversion sequencer.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    result_d = result_q;
    trip_d   = trip_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          mode_d  = i_mode;
          code_d  = first_code;
          bit_d   = MSB_IDX;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_SAMPLE: begin
        case (mode_q)
          MODE_STATIC: begin
            result_d = code_q;
            trip_d   = 1'b0;
            state_d  = ST_DONE;
          end

          MODE_UP: begin
            if (comp_s) begin
              result_d = code_q;
              trip_d   = 1'b1;
              state_d  = ST_DONE;
            end else if (code_q == CODE_MAX) begin
              result_d = CODE_MAX;
              trip_d   = 1'b0;
              state_d  = ST_DONE;
            end else begin
              code_d  = code_q + 1'b1;
              cnt_d   = CNT_LOAD;
              state_d = ST_SETTLE;
            end
          end

          MODE_DOWN: begin
            if (!comp_s) begin
              result_d = code_q;
              trip_d   = 1'b1;
              state_d  = ST_DONE;
            end else if (code_q == '0) begin
              result_d = '0;
              trip_d   = 1'b0;
              state_d  = ST_DONE;
            end else begin
              code_d  = code_q - 1'b1;
              cnt_d   = CNT_LOAD;
              state_d = ST_SETTLE;
            end
          end

          default: begin
            code_d = sar_next;
            if (bit_q != '0) begin
              bit_d   = bit_q - 1'b1;
              cnt_d   = CNT_LOAD;
              state_d = ST_SETTLE;
            end else begin
              result_d = sar_next;
              trip_d   = 1'b0;
              state_d  = ST_DONE;
            end
          end
        endcase
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort discards the conversion in flight but keeps the last completed result.
    if (i_abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      code_d   = '0;
      cnt_d    = '0;
      result_d = result_q;
      trip_d   = trip_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_STATIC;
      code_q   <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      result_q <= '0;
      trip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      result_q <= result_d;
      trip_q   <= trip_d;
    end
  end

  assign o_dac_data   = code_q;
  assign o_dac_enable = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);
  assign o_result     = result_q;
  assign o_trip       = trip_q;

endmodule
